// File: rtl/r200_pkg.sv
// Shared definitions for the r200 boot path: loader state encoding and the
// default frame start marker.
package r200_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // States in which a frame is partially received.
    function automatic logic is_frame_state(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses SYNC/LEN/payload/CSUM frames into the instruction ram
// and holds the CPU in reset until a verified image is present. Optional idle timeout: IMEM_LOADER_TIMEOUT_EN.
module imem_loader
    import r200_pkg::*;
#(
    parameter int         ADDR_W      = 10,
    parameter int         DEPTH       = 1024,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] LEN_MAX = 17'(DEPTH);

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_len;
    logic [15:0]         w_len_next;
    logic [15:0]         r_count;
    logic [15:0]         w_count_next;
    logic [7:0]          r_sum;
    logic [7:0]          w_sum_next;
    logic                r_in_ready;
    logic                r_mem_we;
    logic                w_mem_we_next;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   w_mem_addr_next;
    logic [7:0]          r_mem_wdata;
    logic [7:0]          w_mem_wdata_next;
    logic                r_cpu_rst;
    logic                w_cpu_rst_next;
    logic                r_done;
    logic                w_done_next;
    logic                r_err;
    logic                w_err_next;
    logic                w_accept;
    logic [16:0]         w_len_full;

    assign w_accept   = in_valid && r_in_ready;
    assign w_len_full = {1'b0, in_data, r_len[7:0]};

`ifdef IMEM_LOADER_TIMEOUT_EN
    // Idle-cycle watchdog; only counts while a frame is partially received.
    logic [15:0] r_idle;
    logic        w_in_frame;
    logic        w_timeout;

    assign w_in_frame = is_frame_state(r_state);
    assign w_timeout  = w_in_frame && !w_accept && (r_idle == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_in_frame && !w_accept) begin
            r_idle <= r_idle + 16'd1;
        end else begin
            r_idle <= '0;
        end
    end
`else
    logic w_timeout;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_len_next       = r_len;
        w_count_next     = r_count;
        w_sum_next       = r_sum;
        w_mem_we_next    = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_cpu_rst_next   = r_cpu_rst;
        w_done_next      = r_done;
        w_err_next       = r_err;

        case (r_state)
            IDLE, DONE, ERR: begin
                if (w_accept && (in_data == SYNC_BYTE)) begin
                    w_state_next   = LEN_LO;
                    w_count_next   = '0;
                    w_sum_next     = '0;
                    w_cpu_rst_next = 1'b1;
                    w_done_next    = 1'b0;
                    w_err_next     = 1'b0;
                end
            end
            LEN_LO: begin
                if (w_accept) begin
                    w_len_next[7:0] = in_data;
                    w_state_next    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (w_accept) begin
                    w_len_next = w_len_full[15:0];
                    if (w_len_full > LEN_MAX) begin
                        w_state_next = ERR;
                        w_err_next   = 1'b1;
                        w_done_next  = 1'b0;
                    end else if (w_len_full == 17'd0) begin
                        w_state_next = CSUM;
                    end else begin
                        w_state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_accept) begin
                    w_mem_we_next    = 1'b1;
                    w_mem_addr_next  = r_count[ADDR_W-1:0];
                    w_mem_wdata_next = in_data;
                    w_count_next     = r_count + 16'd1;
                    w_sum_next       = r_sum + in_data;
                    if (r_count == (r_len - 16'd1)) begin
                        w_state_next = CSUM;
                    end
                end
            end
            CSUM: begin
                if (w_accept) begin
                    if (in_data == r_sum) begin
                        w_state_next   = DONE;
                        w_done_next    = 1'b1;
                        w_err_next     = 1'b0;
                        w_cpu_rst_next = 1'b0;
                    end else begin
                        w_state_next = ERR;
                        w_err_next   = 1'b1;
                        w_done_next  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A stalled frame is abandoned; the CPU stays held.
        if (w_timeout) begin
            w_state_next   = ERR;
            w_err_next     = 1'b1;
            w_done_next    = 1'b0;
            w_cpu_rst_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_len       <= w_len_next;
            r_count     <= w_count_next;
            r_sum       <= w_sum_next;
            r_in_ready  <= 1'b1;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_cpu_rst   <= w_cpu_rst_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level scoreboard of expected writes and
// status changes, compared every cycle, plus directed frames with literal expectations.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int TMO    = 100;

    logic              clock = 1'b0;
    logic              rst   = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    imem_loader #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
    ) dut (
        .clock(clock), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic ready_exp;
    always @(posedge clock or posedge rst) begin
        if (rst) ready_exp <= 1'b0;
        else     ready_exp <= 1'b1;
    end

    typedef struct { int cyc; int addr; int data; } wr_t;
    typedef struct { int cyc; logic d; logic e; logic c; } st_t;

    wr_t  wq[$];
    st_t  sq[$];
    wr_t  wlog[$];
    logic exp_done = 1'b0;
    logic exp_err  = 1'b0;
    logic exp_cpu  = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the scoreboard.
    always @(negedge clock) begin
        if (rst) begin
            exp_done = 1'b0;
            exp_err  = 1'b0;
            exp_cpu  = 1'b1;
            wq.delete();
            sq.delete();
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
            chk("rst_cpu_rst", 32'(cpu_rst), 1);
            chk("rst_done", 32'(done), 0);
            chk("rst_err", 32'(err), 0);
        end else begin
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                exp_done = sq[0].d;
                exp_err  = sq[0].e;
                exp_cpu  = sq[0].c;
                void'(sq.pop_front());
            end
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                chk("mem_we_missing", 32'(mem_we), 1);
                void'(wq.pop_front());
            end
            if (mem_we) wlog.push_back('{cyc, int'(mem_addr), int'(mem_wdata)});
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                chk("mem_we", 32'(mem_we), 1);
                chk("mem_addr", 32'(mem_addr), wq[0].addr);
                chk("mem_wdata", 32'(mem_wdata), wq[0].data);
                void'(wq.pop_front());
            end else begin
                chk("mem_we_idle", 32'(mem_we), 0);
            end
            chk("in_ready", 32'(in_ready), 32'(ready_exp));
            chk("done", 32'(done), 32'(exp_done));
            chk("err", 32'(err), 32'(exp_err));
            chk("cpu_rst", 32'(cpu_rst), 32'(exp_cpu));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    // Drives one byte after 'gap' idle cycles; returns the cycle its effect becomes visible.
    task automatic send_byte(input logic [7:0] b, input int gap, output int eff);
        idle(gap);
        @(posedge clock); #1;
        in_valid = 1'b1;
        in_data  = b;
        eff      = cyc + 1;
    endtask

    function automatic int rgap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
    endfunction

    task automatic send_frame(input logic [15:0] n, input logic [7:0] pl[$],
                              input logic [7:0] csum, input int maxgap);
        int         c;
        logic [7:0] s;
        send_byte(8'hA5, rgap(maxgap), c);
        sq.push_back('{c, 1'b0, 1'b0, 1'b1});
        send_byte(n[7:0], rgap(maxgap), c);
        send_byte(n[15:8], rgap(maxgap), c);
        if (int'(n) > DEPTH) begin
            sq.push_back('{c, 1'b0, 1'b1, 1'b1});
        end else begin
            s = 8'h00;
            for (int i = 0; i < int'(n); i++) begin
                send_byte(pl[i], rgap(maxgap), c);
                wq.push_back('{c, i % (1 << ADDR_W), int'(pl[i])});
                s = s + pl[i];
            end
            send_byte(csum, rgap(maxgap), c);
            if (csum == s) sq.push_back('{c, 1'b1, 1'b0, 1'b0});
            else           sq.push_back('{c, 1'b0, 1'b1, 1'b1});
        end
        idle(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] exp1[4];
        logic [7:0] s, gb, csum;
        logic [15:0] n;
        int c, ng, r;

        exp1[0] = 8'h13; exp1[1] = 8'h01; exp1[2] = 8'h30; exp1[3] = 8'h00;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Basic frame A5 04 00 13 01 30 00 44.
        wlog.delete();
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(exp1[i]);
        send_frame(16'd4, pl, 8'h44, 0);
        idle(3);
        chk("f1_nwrites", wlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) begin
                chk("f1_addr", wlog[i].addr, i);
                chk("f1_data", wlog[i].data, 32'(exp1[i]));
            end
        end
        chk("f1_done", 32'(done), 1);
        chk("f1_cpu_rst", 32'(cpu_rst), 0);

        // Same frame with a bad checksum, then a good one.
        wlog.delete();
        send_frame(16'd4, pl, 8'h45, 1);
        idle(3);
        chk("f2_nwrites", wlog.size(), 4);
        chk("f2_err", 32'(err), 1);
        chk("f2_done", 32'(done), 0);
        chk("f2_cpu_rst", 32'(cpu_rst), 1);
        send_frame(16'd4, pl, 8'h44, 1);
        idle(3);
        chk("f2b_done", 32'(done), 1);
        chk("f2b_cpu_rst", 32'(cpu_rst), 0);

        // Leading garbage, then a frame whose payload is the sync value.
        wlog.delete();
        send_byte(8'h00, 0, c);
        send_byte(8'hFF, 0, c);
        send_byte(8'h12, 0, c);
        pl.delete();
        pl.push_back(8'hA5);
        send_frame(16'd1, pl, 8'hA5, 0);
        idle(3);
        chk("f3_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) begin
            chk("f3_addr", wlog[0].addr, 0);
            chk("f3_data", wlog[0].data, 32'hA5);
        end
        chk("f3_done", 32'(done), 1);

        // Oversized length and empty payload.
        wlog.delete();
        pl.delete();
        send_frame(16'h0401, pl, 8'h00, 0);
        idle(3);
        chk("f4_nwrites", wlog.size(), 0);
        chk("f4_err", 32'(err), 1);
        chk("f4_cpu_rst", 32'(cpu_rst), 1);
        send_frame(16'h0000, pl, 8'h00, 0);
        idle(3);
        chk("f5_nwrites", wlog.size(), 0);
        chk("f5_done", 32'(done), 1);

        // Largest accepted frame reaches the last address.
        wlog.delete();
        pl.delete();
        s = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            pl.push_back(8'($urandom));
            s = s + pl[i];
        end
        send_frame(16'(DEPTH), pl, s, 0);
        idle(3);
        chk("f6_nwrites", wlog.size(), DEPTH);
        if (wlog.size() == DEPTH) chk("f6_last_addr", wlog[DEPTH-1].addr, DEPTH - 1);
        chk("f6_done", 32'(done), 1);

        // Reset after two of four payload bytes, then a clean reload.
        send_byte(8'hA5, 0, c);
        sq.push_back('{c, 1'b0, 1'b0, 1'b1});
        send_byte(8'h04, 0, c);
        send_byte(8'h00, 0, c);
        send_byte(8'h13, 0, c);
        wq.push_back('{c, 0, 32'h13});
        send_byte(8'h01, 0, c);
        wq.push_back('{c, 1, 32'h01});
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("f7_done", 32'(done), 0);
        chk("f7_err", 32'(err), 0);
        chk("f7_cpu_rst", 32'(cpu_rst), 1);
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(exp1[i]);
        send_frame(16'd4, pl, 8'h44, 1);
        idle(3);
        chk("f7b_done", 32'(done), 1);

        // Stalled frame.
        send_byte(8'hA5, 0, c);
        sq.push_back('{c, 1'b0, 1'b0, 1'b1});
        send_byte(8'h04, 0, c);
        send_byte(8'h00, 0, c);
        send_byte(8'h13, 0, c);
        wq.push_back('{c, 0, 32'h13});
`ifdef IMEM_LOADER_TIMEOUT_EN
        sq.push_back('{c + TMO, 1'b0, 1'b1, 1'b1});
        idle(TMO + 5);
        chk("f8_err", 32'(err), 1);
        chk("f8_cpu_rst", 32'(cpu_rst), 1);
`else
        idle(1000);
        for (int i = 1; i < 4; i++) begin
            send_byte(exp1[i], 0, c);
            wq.push_back('{c, i, 32'(exp1[i])});
        end
        send_byte(8'h44, 0, c);
        sq.push_back('{c, 1'b1, 1'b0, 1'b0});
        idle(3);
        chk("f8_done", 32'(done), 1);
        chk("f8_cpu_rst", 32'(cpu_rst), 0);
`endif

        // Randomized frames with garbage, gaps, bad checksums and oversized lengths.
        for (int f = 0; f < 40; f++) begin
            ng = $urandom_range(3, 0);
            for (int g = 0; g < ng; g++) begin
                gb = 8'($urandom);
                if (gb == 8'hA5) gb = 8'h5A;
                send_byte(gb, rgap(2), c);
            end
            r = $urandom_range(9, 0);
            if (r == 0)      n = 16'd0;
            else if (r == 1) n = 16'(DEPTH + 1 + int'($urandom_range(200, 0)));
            else             n = 16'($urandom_range(24, 1));
            pl.delete();
            s = 8'h00;
            if (int'(n) <= DEPTH) begin
                for (int i = 0; i < int'(n); i++) begin
                    pl.push_back(($urandom_range(7, 0) == 0) ? 8'hA5 : 8'($urandom));
                    s = s + pl[i];
                end
            end
            csum = s;
            if ($urandom_range(3, 0) == 0) csum = s + 8'($urandom_range(255, 1));
            send_frame(n, pl, csum, 2);
        end

        idle(5);
        chk("pending_writes", wq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream boot loader that fills the r200 instruction memory (byte-wide ram) from an external source, in place of testbench preloading.
- Holds the CPU in reset while loading, checks a framed payload, then releases the CPU.
- Sits between a host byte link (UART receiver or debug port) and the instrnmem write port; drives the CPU reset alongside the system reset.

Parameters:
ADDR_W, 10, instruction-memory byte address width
DEPTH, 1024, memory size in bytes; largest accepted payload length
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 65535, idle-cycle limit inside a frame (optional feature only)

Ports:
clock  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  byte available on in_data
in_data  in  8  stream byte
in_ready  out  1  loader can accept a byte
mem_we  out  1  single-cycle byte write strobe to the instruction ram
mem_addr  out  ADDR_W  byte write address
mem_wdata  out  8  byte write data
cpu_rst  out  1  CPU reset (pc_rst source); high = CPU held
done  out  1  last frame loaded with a good checksum
err  out  1  last frame rejected

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0, state=IDLE, len=0, count=0, sum=0.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready. in_ready=1 in every state outside reset; there is no backpressure. in_data is ignored when in_valid=0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit byte count N, little-endian), N payload bytes, then CSUM. CSUM is the mod-256 sum of the payload bytes.
- State IDLE: non-sync bytes are discarded. SYNC -> LEN_LO and clears count and sum.
- State LEN_LO: the accepted byte is stored -> LEN_HI.
- State LEN_HI: the accepted byte is stored.
  - N > DEPTH -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
- State DATA: on accept, register mem_we=1, mem_addr=count[ADDR_W-1:0], mem_wdata=byte for exactly the next cycle (write latency 1), then count++ and sum+=byte. After the byte with count==N-1 -> CSUM.
- State CSUM: on accept, compare with sum.
  - Match -> DONE.
  - Mismatch -> ERR.
- Entering DONE sets done=1, err=0, and cpu_rst=0 on the edge after the CSUM accept.
- Entering ERR sets err=1, done=0; cpu_rst stays 1.
- DONE and ERR behave like IDLE: non-sync bytes are ignored. SYNC starts a new frame: cpu_rst=1 on the next edge, done=0, err=0.
- The CPU therefore runs only after a complete, verified image; a rejected image keeps the CPU held.
- mem_we is never asserted outside DATA. Bytes already written by a rejected frame are not rolled back.
- The address wraps only via truncation; it is unreachable because N ≤ DEPTH.
- A SYNC_BYTE value inside LEN, DATA or CSUM is treated as data (no resync).
- rst asserted mid-frame aborts immediately to the reset values; a partial image remains in ram.

Optional Feature:
- Macro IMEM_LOADER_TIMEOUT_EN.
- When defined: a 16-bit idle counter clears on every accept and increments each cycle in LEN_LO, LEN_HI, DATA or CSUM without an accept. Reaching TIMEOUT_CYC -> ERR (err=1, cpu_rst=1). The counter is held at 0 in IDLE, DONE and ERR.
- When undefined: no counter exists, and a stalled frame waits indefinitely.

Decomposition:
- Shared package r200_pkg: the state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR) and the SYNC_BYTE default constant.
- No sub-module: checksum and counters are inline. The timeout counter is an inline generate/ifdef block, not a separate module.

Test Plan:
- Frame A5 04 00 13 01 30 00 44 -> four mem_we pulses: addr 0..3, data 13,01,30,00, each one cycle after its accept; done=1; cpu_rst falls the cycle after 44 is accepted.
- Same frame with CSUM 45 -> four writes occur, err=1, done=0, cpu_rst stays 1; a following good frame -> done=1, cpu_rst=0.
- Leading garbage 00 FF 12, then a good frame A5 01 00 A5 A5 -> garbage ignored with no mem_we; the payload byte A5 is written to addr 0; done=1.
- Length 0x0401 (1025) with DEPTH=1024 -> err=1 after LEN_HI with no mem_we; length 0 with CSUM 00 -> done=1 with no writes.
- rst pulse after 2 of 4 payload bytes -> all outputs take their reset values, state IDLE; the next full frame loads correctly.
- With IMEM_LOADER_TIMEOUT_EN and TIMEOUT_CYC=100: send A5 04 00 13, then in_valid=0 for 100 cycles -> err=1, cpu_rst=1. Without the macro -> still in DATA after 1000 idle cycles.
